// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
//   Multi-cycle signed integer divider. Radix-2 restoring division on operand
//   magnitudes, one quotient bit per enabled cycle, followed by a sign-fix
//   cycle and a one-cycle done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   en           clock enable; 0 freezes every register and output
//   start        request, sampled only in IDLE while en=1
//   a, b         signed dividend / divisor, sampled with an accepted start
//   quotient     signed quotient, truncated toward zero
//   remainder    signed remainder, sign follows the dividend
//   busy         high from the cycle after acceptance until done
//   done         single-cycle pulse, results valid from this cycle
//   div_by_zero  set with done when b was 0
//   overflow     set with done when a was MIN and b was -1
// -----------------------------------------------------------------------------
module sequential_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   q_r;        // dividend magnitude, shifted out as quotient bits come in
    logic [WIDTH-1:0]   r_r;        // partial remainder, always < |b| so WIDTH bits suffice
    logic [WIDTH:0]     mag_b_r;    // |b| with an extra bit so |MIN| is representable
    logic               sign_q_r;
    logic               sign_r_r;
    logic               dz_r;
    logic               ovf_r;

    logic [WIDTH:0]     shift_s;    // {R,Q} shifted left by one, upper part only
    logic               ge_s;       // trial subtraction does not go negative

    // Shifted partial remainder and trial-subtraction comparison for CALC.
    assign shift_s = {r_r, q_r[WIDTH-1]};
    assign ge_s    = (shift_s >= mag_b_r);

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            q_r         <= ZERO_VAL;
            r_r         <= ZERO_VAL;
            mag_b_r     <= {(WIDTH+1){1'b0}};
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= ZERO_VAL;
            remainder   <= ZERO_VAL;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (en) begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_q_r    <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r_r    <= a[WIDTH-1];
                        // -MIN wraps to MIN, which read unsigned is exactly |MIN|.
                        q_r         <= a[WIDTH-1] ? -a : a;
                        r_r         <= ZERO_VAL;
                        mag_b_r     <= {1'b0, (b[WIDTH-1] ? -b : b)};
                        dz_r        <= (b == ZERO_VAL);
                        ovf_r       <= (a == MIN_VAL) && (b == ALL_ONES);
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        cnt_r       <= CNT_W'(WIDTH - 1);
                        state_r     <= (b == ZERO_VAL) ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_r <= WIDTH'(ge_s ? (shift_s - mag_b_r) : shift_s);
                    q_r <= {q_r[WIDTH-2:0], ge_s};
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (dz_r) begin
                        // No iterations ran, so q_r still holds |a| and this restores a.
                        quotient    <= ALL_ONES;
                        remainder   <= sign_r_r ? -q_r : q_r;
                        div_by_zero <= 1'b1;
                    end else if (ovf_r) begin
                        quotient    <= MIN_VAL;
                        remainder   <= ZERO_VAL;
                        overflow    <= 1'b1;
                    end else begin
                        quotient    <= sign_q_r ? -q_r : q_r;
                        remainder   <= sign_r_r ? -r_r : r_r;
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    // The start input is not looked at here; it must be presented in IDLE.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
